// File: rtl/iobus_req_port.sv
// Fast-side I/O-bus requester: launches one IORDREQ/IOWRREQ per CPU cycle and tracks it via synchronized IOACT/IOBERR.
// Optional posted writes are enabled by defining IOBUS_POSTED_WRITE_EN.
module iobus_req_port #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RES,
    input  logic CPU_REQ,
    input  logic CPU_WR,
    input  logic CPU_LDS,
    input  logic CPU_UDS,
    output logic CPU_ACK,
    output logic CPU_BERR,
    output logic WBERR,
    input  logic WBERR_CLR,
    output logic BUSY,
    output logic ALE0S,
    output logic IORDREQ,
    output logic IOWRREQ,
    output logic IOLDS,
    output logic IOUDS,
    input  logic IOACT,
    input  logic IOBERR
);

    typedef enum logic [1:0] {IDLE, REQ, ACT, DONE} state_t;

`ifdef IOBUS_POSTED_WRITE_EN
    localparam bit POSTED_EN = 1'b1;
`else
    localparam bit POSTED_EN = 1'b0;
`endif

    state_t state_reg, state_next;
    logic [SYNC_STAGES-1:0] act_sync_reg, berr_sync_reg;
    logic [2:0] settle_reg, settle_next;
    logic armed_reg, armed_next;
    logic ack_reg, ack_next;
    logic cpu_berr_reg, cpu_berr_next;
    logic wberr_reg, wberr_next;
    logic busy_reg, busy_next;
    logic ale_reg, ale_next;
    logic rdreq_reg, rdreq_next;
    logic wrreq_reg, wrreq_next;
    logic lds_reg, lds_next;
    logic uds_reg, uds_next;
    logic berracc_reg, berracc_next;
    logic posted_reg, posted_next;
    logic wberr_set;
    logic act_s, berr_s, settle_done;

    assign act_s  = act_sync_reg[SYNC_STAGES-1];
    assign berr_s = berr_sync_reg[SYNC_STAGES-1];
    // The chains restart empty after reset, so ACTs means nothing until they have refilled.
    assign settle_done = (settle_reg == 3'(SYNC_STAGES));

    always_comb begin
        state_next    = state_reg;
        armed_next    = armed_reg | ~CPU_REQ;
        ack_next      = 1'b0;
        cpu_berr_next = 1'b0;
        busy_next     = busy_reg;
        ale_next      = ale_reg;
        rdreq_next    = rdreq_reg;
        wrreq_next    = wrreq_reg;
        lds_next      = lds_reg;
        uds_next      = uds_reg;
        berracc_next  = berracc_reg;
        posted_next   = posted_reg;
        wberr_set     = 1'b0;
        settle_next   = settle_done ? settle_reg : settle_reg + 3'd1;
        case (state_reg)
            IDLE: begin
                if (CPU_REQ && armed_reg && !act_s && settle_done) begin
                    ale_next     = 1'b0;
                    lds_next     = CPU_LDS;
                    uds_next     = CPU_UDS;
                    rdreq_next   = ~CPU_WR;
                    wrreq_next   = CPU_WR;
                    busy_next    = 1'b1;
                    berracc_next = 1'b0;
                    posted_next  = POSTED_EN & CPU_WR;
                    ack_next     = POSTED_EN & CPU_WR;
                    state_next   = REQ;
                end
            end
            REQ: begin
                if (act_s) begin
                    rdreq_next = 1'b0;
                    wrreq_next = 1'b0;
                    state_next = ACT;
                end
            end
            ACT: begin
                berracc_next = berracc_reg | berr_s;
                if (!act_s) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ale_next   = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
                if (posted_reg) begin
                    wberr_set = berracc_reg | berr_s;
                end else begin
                    ack_next      = 1'b1;
                    cpu_berr_next = berracc_reg | berr_s;
                end
            end
            default: state_next = IDLE;
        endcase
        if (ack_next) begin
            armed_next = 1'b0;
        end
    end

`ifdef IOBUS_POSTED_WRITE_EN
    always_comb begin
        wberr_next = wberr_reg;
        if (WBERR_CLR) begin
            wberr_next = 1'b0;
        end else if (wberr_set) begin
            wberr_next = 1'b1;
        end
    end
`else
    logic unused_wberr;
    assign unused_wberr = WBERR_CLR | wberr_set | wberr_reg;
    always_comb begin
        wberr_next = 1'b0;
    end
`endif

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_reg     <= IDLE;
            act_sync_reg  <= '0;
            berr_sync_reg <= '0;
            settle_reg    <= 3'd0;
            armed_reg     <= 1'b1;
            ack_reg       <= 1'b0;
            cpu_berr_reg  <= 1'b0;
            wberr_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            ale_reg       <= 1'b1;
            rdreq_reg     <= 1'b0;
            wrreq_reg     <= 1'b0;
            lds_reg       <= 1'b0;
            uds_reg       <= 1'b0;
            berracc_reg   <= 1'b0;
            posted_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            act_sync_reg  <= {act_sync_reg[SYNC_STAGES-2:0], IOACT};
            berr_sync_reg <= {berr_sync_reg[SYNC_STAGES-2:0], IOBERR};
            settle_reg    <= settle_next;
            armed_reg     <= armed_next;
            ack_reg       <= ack_next;
            cpu_berr_reg  <= cpu_berr_next;
            wberr_reg     <= wberr_next;
            busy_reg      <= busy_next;
            ale_reg       <= ale_next;
            rdreq_reg     <= rdreq_next;
            wrreq_reg     <= wrreq_next;
            lds_reg       <= lds_next;
            uds_reg       <= uds_next;
            berracc_reg   <= berracc_next;
            posted_reg    <= posted_next;
        end
    end

    assign CPU_ACK  = ack_reg;
    assign CPU_BERR = cpu_berr_reg;
    assign WBERR    = wberr_reg;
    assign BUSY     = busy_reg;
    assign ALE0S    = ale_reg;
    assign IORDREQ  = rdreq_reg;
    assign IOWRREQ  = wrreq_reg;
    assign IOLDS    = lds_reg;
    assign IOUDS    = uds_reg;

endmodule

// File: doc/iobus_req_port.md
Name: iobus_req_port

Overview:
- Fast-side requester for the I/O bus; the initiator end of the IORDREQ/IOWRREQ/IOLDS/IOUDS to IOACT/IOBERR handshake.
- Accepts single accelerated-CPU I/O cycles and closes the shared address/data latch (ALE0S).
- Issues one I/O-bus request per cycle, tracks completion through synchronized IOACT, and acknowledges the CPU.
- Writes can be posted so the CPU does not wait for the slow bus.

Parameters:
- SYNC_STAGES, 2: flip-flop depth for synchronizing IOACT and IOBERR into CLK; legal range 2..4.

Ports:
- CLK  in  1  fast CPU clock; sole clock.
- RES  in  1  reset, synchronous, active-high.
- CPU_REQ  in  1  I/O-space cycle request (level); held until CPU_ACK.
- CPU_WR  in  1  1 = write, 0 = read; valid with CPU_REQ.
- CPU_LDS  in  1  lower byte lane enable, active-high.
- CPU_UDS  in  1  upper byte lane enable, active-high.
- CPU_ACK  out  1  one-cycle cycle-termination pulse.
- CPU_BERR  out  1  bus error; valid only with CPU_ACK.
- WBERR  out  1  sticky: a posted write ended in bus error.
- WBERR_CLR  in  1  clears WBERR.
- BUSY  out  1  an I/O transaction is outstanding.
- ALE0S  out  1  address/data latch enable; 1 = transparent, 0 = hold.
- IORDREQ  out  1  read request to the I/O bus master.
- IOWRREQ  out  1  write request to the I/O bus master.
- IOLDS  out  1  latched lower lane.
- IOUDS  out  1  latched upper lane.
- IOACT  in  1  master-active, from the other clock domain.
- IOBERR  in  1  master bus error, from the other clock domain.

Behaviour:
- Synchronization: IOACT and IOBERR each pass through SYNC_STAGES flops, giving ACTs and BERRs. No combinational use of the raw inputs.
- Reset (RES=1 at a CLK edge), regardless of state:
  - State goes to IDLE; ARMED=1.
  - CPU_ACK=0, CPU_BERR=0, WBERR=0, BUSY=0, ALE0S=1, IORDREQ=0, IOWRREQ=0, IOLDS=0, IOUDS=0.
  - Sync chains clear.
  - A reset mid-transaction drops the request immediately. Master-side cleanup is the master's concern.
- ARMED:
  - Cleared on every CPU_ACK.
  - Set on any cycle with CPU_REQ=0.
  - A CPU_REQ is accepted only when ARMED=1, so a held CPU_REQ never launches a second transaction.
- States: IDLE, REQ, ACT, DONE. All outputs are registered.
- IDLE:
  - Accept condition: CPU_REQ && ARMED && !ACTs.
  - On accept: ALE0S<=0; IOLDS<=CPU_LDS; IOUDS<=CPU_UDS; IORDREQ<=!CPU_WR or IOWRREQ<=CPU_WR; BUSY<=1; BERRACC<=0; WR latched; state goes to REQ.
  - If ACTs is still 1 from a previous transaction, acceptance waits.
- REQ:
  - Request stays asserted until ACTs=1.
  - On ACTs=1: IORDREQ<=0, IOWRREQ<=0, state goes to ACT.
  - No timeout.
- ACT:
  - Each cycle: BERRACC <= BERRACC | BERRs.
  - When ACTs=0: state goes to DONE.
- DONE (one cycle):
  - ALE0S<=1, BUSY<=0, state goes to IDLE.
  - If the transaction is not posted: CPU_ACK=1, CPU_BERR=BERRACC | BERRs.
  - If it was a posted write: WBERR <= WBERR | BERRACC | BERRs. No CPU_ACK.
- IOLDS and IOUDS stay stable from the accept cycle until IDLE is re-entered.
- Read latency with IOACT toggling ideally: CPU_ACK is asserted SYNC_STAGES+1 cycles after the IOACT fall.
- WBERR_CLR has priority over a simultaneous WBERR set; the set is lost.
- CPU_REQ deasserted mid-transaction has no effect on the transaction in progress.

Optional Feature:
- Macro: IOBUS_POSTED_WRITE_EN.
- Defined:
  - A write accepted in IDLE gives CPU_ACK=1 (CPU_BERR=0) on the cycle after acceptance.
  - The transaction then completes in the background and its error is reported only via WBERR.
  - A new CPU_REQ while BUSY=1 is stalled, with no ACK, until IDLE.
- Undefined:
  - Writes terminate like reads in DONE.
  - WBERR is tied to 0 and WBERR_CLR is ignored.

Test Plan:
- Read, SYNC_STAGES=2:
  - Stimulus: CPU_REQ=1, CPU_WR=0, CPU_LDS=1, CPU_UDS=0; IOACT rises 3 cycles after IORDREQ, high 10 cycles, then falls.
  - Required: IORDREQ drops 2 cycles after the IOACT rise; IOLDS=1, IOUDS=0 throughout; CPU_ACK one pulse 3 cycles after the IOACT fall; CPU_BERR=0; ALE0S is 0 from accept until DONE.
- Read with IOBERR=1 pulsed for 2 cycles mid-ACT:
  - Required: CPU_ACK together with CPU_BERR=1.
- Held CPU_REQ after ACK:
  - Stimulus: keep CPU_REQ=1 for 20 cycles after CPU_ACK.
  - Required: no new IORDREQ or IOWRREQ. Drop CPU_REQ for 1 cycle and reassert: a new request is issued.
- Posted write (IOBUS_POSTED_WRITE_EN):
  - Stimulus: a write whose transaction ends with IOBERR=1.
  - Required: CPU_ACK the cycle after accept; WBERR=1 after DONE; WBERR_CLR=1 returns WBERR to 0.
  - A second CPU_REQ issued while BUSY gets no ACK until the first transaction completes.
- Reset mid-ACT:
  - Stimulus: RES=1 for 1 cycle while IOACT=1.
  - Required next cycle: IORDREQ=0, IOWRREQ=0, BUSY=0, ALE0S=1, CPU_ACK=0.
  - A new request is not issued until IOACT has synced to 0.
